// File: rtl/csr_reg.sv
// Machine-mode CSR file: execute and clint write/read ports, live trap CSRs, 64-bit mcycle.
// Optional 64-bit minstret is built only when CSR_MINSTRET_EN is defined.
module csr_reg #(
    parameter logic [31:0] MISA_VAL = 32'h40000100,
    parameter logic [31:0] HART_ID  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_wen_i,
    input  logic [31:0] ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [31:0] ex_raddr_i,
    output logic [31:0] ex_rdata_o,
    input  logic        clint_wen_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_wdata_i,
    input  logic [31:0] clint_raddr_i,
    output logic [31:0] clint_rdata_o,
    input  logic        inst_retire_i,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_MINSTRET_EN
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_MSTATUS,
        SEL_MISA,
        SEL_MIE,
        SEL_MTVEC,
        SEL_MSCRATCH,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_MHARTID
    } csr_sel_t;

    function automatic csr_sel_t decode(input logic [31:0] addr);
        csr_sel_t sel;
        sel = SEL_NONE;
        if (addr[31:12] == 20'd0) begin
            case (addr[11:0])
                ADDR_MSTATUS:   sel = SEL_MSTATUS;
                ADDR_MISA:      sel = SEL_MISA;
                ADDR_MIE:       sel = SEL_MIE;
                ADDR_MTVEC:     sel = SEL_MTVEC;
                ADDR_MSCRATCH:  sel = SEL_MSCRATCH;
                ADDR_MEPC:      sel = SEL_MEPC;
                ADDR_MCAUSE:    sel = SEL_MCAUSE;
                ADDR_MCYCLE:    sel = SEL_MCYCLE;
                ADDR_MCYCLEH:   sel = SEL_MCYCLEH;
                ADDR_MHARTID:   sel = SEL_MHARTID;
`ifdef CSR_MINSTRET_EN
                ADDR_MINSTRET:  sel = SEL_MINSTRET;
                ADDR_MINSTRETH: sel = SEL_MINSTRETH;
`endif
                default:        sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic writable(input csr_sel_t sel);
        case (sel)
            SEL_MSTATUS, SEL_MIE, SEL_MTVEC, SEL_MSCRATCH, SEL_MEPC, SEL_MCAUSE,
            SEL_MCYCLE, SEL_MCYCLEH, SEL_MINSTRET, SEL_MINSTRETH: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // Masking happens before the bypass mux so readers never see unmasked data.
    function automatic logic [31:0] mask_wdata(input csr_sel_t sel, input logic [31:0] data);
        case (sel)
            SEL_MSTATUS:         return (data & MSTATUS_WMASK) | MSTATUS_FIXED;
            SEL_MIE:             return data & MIE_WMASK;
            SEL_MTVEC, SEL_MEPC: return data & ALIGN_MASK;
            default:             return data;
        endcase
    endfunction

    function automatic logic [63:0] counter_next(
        input logic [63:0] cur,
        input logic        inc,
        input logic        lo_wr,
        input logic [31:0] lo_val,
        input logic        hi_wr,
        input logic [31:0] hi_val
    );
        logic [63:0] nxt;
        nxt = (lo_wr || hi_wr || !inc) ? cur : cur + 64'd1;
        if (lo_wr) nxt[31:0]  = lo_val;
        if (hi_wr) nxt[63:32] = hi_val;
        return nxt;
    endfunction

    csr_sel_t    ex_sel;
    csr_sel_t    clint_sel;
    csr_sel_t    ex_rsel;
    csr_sel_t    clint_rsel;
    logic [31:0] ex_wval;
    logic [31:0] clint_wval;
    logic [15:0] ex_hit;
    logic [15:0] clint_hit;
    logic [15:0] any_hit;

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [2:0]  mie_q;
    logic [31:2] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [31:0] mstatus_view;
    logic [15:0][31:0] csr_view;

    assign ex_sel     = decode(ex_waddr_i);
    assign clint_sel  = decode(clint_waddr_i);
    assign ex_rsel    = decode(ex_raddr_i);
    assign clint_rsel = decode(clint_raddr_i);
    assign ex_wval    = mask_wdata(ex_sel, ex_wdata_i);
    assign clint_wval = mask_wdata(clint_sel, clint_wdata_i);

    // Write enables are single-cycle strobes with no back-pressure; a clint write to
    // the same CSR suppresses the ex write so at most one source hits each register.
    always_comb begin
        clint_hit = '0;
        ex_hit    = '0;
        if (clint_wen_i && writable(clint_sel)) clint_hit[clint_sel] = 1'b1;
        if (ex_wen_i && writable(ex_sel) && !clint_hit[ex_sel]) ex_hit[ex_sel] = 1'b1;
    end

    assign any_hit = clint_hit | ex_hit;

    logic [31:0] mstatus_wval;
    logic [31:0] mie_wval;
    logic [31:0] mtvec_wval;
    logic [31:0] mscratch_wval;
    logic [31:0] mepc_wval;
    logic [31:0] mcause_wval;
    logic [31:0] mcycle_wval;
    logic [31:0] mcycleh_wval;

    assign mstatus_wval  = clint_hit[SEL_MSTATUS]  ? clint_wval : ex_wval;
    assign mie_wval      = clint_hit[SEL_MIE]      ? clint_wval : ex_wval;
    assign mtvec_wval    = clint_hit[SEL_MTVEC]    ? clint_wval : ex_wval;
    assign mscratch_wval = clint_hit[SEL_MSCRATCH] ? clint_wval : ex_wval;
    assign mepc_wval     = clint_hit[SEL_MEPC]     ? clint_wval : ex_wval;
    assign mcause_wval   = clint_hit[SEL_MCAUSE]   ? clint_wval : ex_wval;
    assign mcycle_wval   = clint_hit[SEL_MCYCLE]   ? clint_wval : ex_wval;
    assign mcycleh_wval  = clint_hit[SEL_MCYCLEH]  ? clint_wval : ex_wval;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
        end else begin
            if (any_hit[SEL_MSTATUS]) begin
                mstatus_mie_q  <= mstatus_wval[3];
                mstatus_mpie_q <= mstatus_wval[7];
            end
            if (any_hit[SEL_MIE])      mie_q      <= {mie_wval[11], mie_wval[7], mie_wval[3]};
            if (any_hit[SEL_MTVEC])    mtvec_q    <= mtvec_wval[31:2];
            if (any_hit[SEL_MSCRATCH]) mscratch_q <= mscratch_wval;
            if (any_hit[SEL_MEPC])     mepc_q     <= mepc_wval[31:2];
            if (any_hit[SEL_MCAUSE])   mcause_q   <= mcause_wval;
            mcycle_q <= counter_next(mcycle_q, 1'b1,
                                     any_hit[SEL_MCYCLE], mcycle_wval,
                                     any_hit[SEL_MCYCLEH], mcycleh_wval);
        end
    end

`ifdef CSR_MINSTRET_EN
    logic [63:0] minstret_q;
    logic [31:0] minstret_wval;
    logic [31:0] minstreth_wval;

    assign minstret_wval  = clint_hit[SEL_MINSTRET]  ? clint_wval : ex_wval;
    assign minstreth_wval = clint_hit[SEL_MINSTRETH] ? clint_wval : ex_wval;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            minstret_q <= '0;
        end else begin
            minstret_q <= counter_next(minstret_q, inst_retire_i,
                                       any_hit[SEL_MINSTRET], minstret_wval,
                                       any_hit[SEL_MINSTRETH], minstreth_wval);
        end
    end
`else
    logic unused_inst_retire;
    assign unused_inst_retire = inst_retire_i;
`endif

    assign mstatus_view = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

    always_comb begin
        csr_view               = '0;
        csr_view[SEL_MSTATUS]  = mstatus_view;
        csr_view[SEL_MISA]     = MISA_VAL;
        csr_view[SEL_MIE]      = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
        csr_view[SEL_MTVEC]    = {mtvec_q, 2'b00};
        csr_view[SEL_MSCRATCH] = mscratch_q;
        csr_view[SEL_MEPC]     = {mepc_q, 2'b00};
        csr_view[SEL_MCAUSE]   = mcause_q;
        csr_view[SEL_MCYCLE]   = mcycle_q[31:0];
        csr_view[SEL_MCYCLEH]  = mcycle_q[63:32];
        csr_view[SEL_MHARTID]  = HART_ID;
`ifdef CSR_MINSTRET_EN
        csr_view[SEL_MINSTRET]  = minstret_q[31:0];
        csr_view[SEL_MINSTRETH] = minstret_q[63:32];
`endif
    end

    // Same-cycle write data is forwarded to readers, clint first.
    always_comb begin
        if (clint_hit[ex_rsel])   ex_rdata_o = clint_wval;
        else if (ex_hit[ex_rsel]) ex_rdata_o = ex_wval;
        else                      ex_rdata_o = csr_view[ex_rsel];
    end

    always_comb begin
        if (clint_hit[clint_rsel])   clint_rdata_o = clint_wval;
        else if (ex_hit[clint_rsel]) clint_rdata_o = ex_wval;
        else                         clint_rdata_o = csr_view[clint_rsel];
    end

    assign csr_mtvec_o   = {mtvec_q, 2'b00};
    assign csr_mepc_o    = {mepc_q, 2'b00};
    assign csr_mstatus_o = mstatus_view;

endmodule

// File: tb/tb_csr_reg.sv
// Bench for csr_reg: table-driven CSR model checked every cycle, plus directed literal checks.
module tb_csr_reg;

    localparam logic [31:0] MISA = 32'h40000100;
    localparam logic [31:0] HART = 32'h0;
`ifdef CSR_MINSTRET_EN
    localparam bit HAS_INST = 1'b1;
`else
    localparam bit HAS_INST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wen;
    logic [31:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_raddr;
    logic [31:0] ex_rdata;
    logic        clint_wen;
    logic [31:0] clint_waddr;
    logic [31:0] clint_wdata;
    logic [31:0] clint_raddr;
    logic [31:0] clint_rdata;
    logic        inst_retire;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    csr_reg #(.MISA_VAL(MISA), .HART_ID(HART)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .ex_wen_i      (ex_wen),
        .ex_waddr_i    (ex_waddr),
        .ex_wdata_i    (ex_wdata),
        .ex_raddr_i    (ex_raddr),
        .ex_rdata_o    (ex_rdata),
        .clint_wen_i   (clint_wen),
        .clint_waddr_i (clint_waddr),
        .clint_wdata_i (clint_wdata),
        .clint_raddr_i (clint_raddr),
        .clint_rdata_o (clint_rdata),
        .inst_retire_i (inst_retire),
        .csr_mtvec_o   (csr_mtvec),
        .csr_mepc_o    (csr_mepc),
        .csr_mstatus_o (csr_mstatus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [0:4095];
    logic [63:0] m_cycle;
    logic [63:0] m_inst;

    function automatic logic [31:0] wmask(input logic [31:0] a);
        if (a[31:12] != 20'd0) return 32'h0;
        case (a[11:0])
            12'h300:                            return 32'h0000_0088;
            12'h304:                            return 32'h0000_0888;
            12'h305, 12'h341:                   return 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'hB00, 12'hB80: return 32'hFFFF_FFFF;
            12'hB02, 12'hB82:                   return HAS_INST ? 32'hFFFF_FFFF : 32'h0;
            default:                            return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] masked(input logic [31:0] a, input logic [31:0] d);
        return (d & wmask(a)) | ((a == 32'h300) ? 32'h0000_1800 : 32'h0);
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] a);
        if (a[31:12] != 20'd0) return 32'h0;
        case (a[11:0])
            12'h301: return MISA;
            12'hF14: return HART;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return HAS_INST ? m_inst[31:0] : 32'h0;
            12'hB82: return HAS_INST ? m_inst[63:32] : 32'h0;
            default: return (wmask(a) != 32'h0) ? m_reg[a[11:0]] : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (clint_wen && clint_waddr == a && wmask(a) != 32'h0) return masked(a, clint_wdata);
        if (ex_wen && ex_waddr == a && wmask(a) != 32'h0) return masked(a, ex_wdata);
        return stored(a);
    endfunction

    function automatic logic in_pair(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
        return (a == lo) || (a == hi);
    endfunction

    task automatic commit(input logic [31:0] a, input logic [31:0] d,
                          inout logic [63:0] cyc, inout logic [63:0] ins);
        case (a)
            32'hB00: cyc[31:0]  = d;
            32'hB80: cyc[63:32] = d;
            32'hB02: ins[31:0]  = d;
            32'hB82: ins[63:32] = d;
            default: m_reg[a[11:0]] = masked(a, d);
        endcase
    endtask

    task automatic model_step();
        logic        c_ok, e_ok, cyc_wr, ins_wr;
        logic [63:0] cyc, ins;
        c_ok   = clint_wen && wmask(clint_waddr) != 32'h0;
        e_ok   = ex_wen && wmask(ex_waddr) != 32'h0 && !(c_ok && clint_waddr == ex_waddr);
        cyc_wr = (c_ok && in_pair(clint_waddr, 32'hB00, 32'hB80)) ||
                 (e_ok && in_pair(ex_waddr, 32'hB00, 32'hB80));
        ins_wr = (c_ok && in_pair(clint_waddr, 32'hB02, 32'hB82)) ||
                 (e_ok && in_pair(ex_waddr, 32'hB02, 32'hB82));
        cyc = cyc_wr ? m_cycle : m_cycle + 64'd1;
        ins = (ins_wr || !(HAS_INST && inst_retire)) ? m_inst : m_inst + 64'd1;
        if (c_ok) commit(clint_waddr, clint_wdata, cyc, ins);
        if (e_ok) commit(ex_waddr, ex_wdata, cyc, ins);
        m_cycle = cyc;
        m_inst  = ins;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) m_reg[i] = 32'h0;
            m_reg[12'h300] = 32'h0000_1800;
            m_cycle = 64'h0;
            m_inst  = 64'h0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("csr_mtvec_o", csr_mtvec, stored(32'h305));
            check("csr_mepc_o", csr_mepc, stored(32'h341));
            check("csr_mstatus_o", csr_mstatus, stored(32'h300));
            check("ex_rdata", ex_rdata, model_read(ex_raddr));
            check("clint_rdata", clint_rdata, model_read(clint_raddr));
        end
    end

    // ---------------- drivers ----------------
    task automatic set_wr(input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                          input logic cw, input logic [31:0] ca, input logic [31:0] cd);
        ex_wen      = ew;
        ex_waddr    = ea;
        ex_wdata    = ed;
        clint_wen   = cw;
        clint_waddr = ca;
        clint_wdata = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_wen    = 1'b0;
        clint_wen = 1'b0;
    endtask

    task automatic set_rd(input logic [31:0] ea, input logic [31:0] ca);
        ex_raddr    = ea;
        clint_raddr = ca;
        #1;
    endtask

    logic [31:0] rst_addr [10] = '{32'h300, 32'h301, 32'h304, 32'h305, 32'h340,
                                   32'h341, 32'h342, 32'hB00, 32'hB80, 32'hF14};
    logic [31:0] rst_exp  [10] = '{32'h0000_1800, 32'h4000_0100, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        rst_n       = 1'b0;
        inst_retire = 1'b0;
        ex_raddr    = 32'h0;
        clint_raddr = 32'h0;
        set_wr(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            set_rd(rst_addr[i], rst_addr[i]);
            check($sformatf("reset_ex_read_%h", rst_addr[i]), ex_rdata, rst_exp[i]);
            check($sformatf("reset_clint_read_%h", rst_addr[i]), clint_rdata, rst_exp[i]);
        end
        check("reset_csr_mstatus_o", csr_mstatus, 32'h0000_1800);
        check("reset_csr_mtvec_o", csr_mtvec, 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // mtvec via ex with same-cycle bypass on the clint read port
        set_wr(1'b1, 32'h305, 32'h8000_0107, 1'b0, 32'h0, 32'h0);
        set_rd(32'h300, 32'h305);
        check("bypass_mtvec", clint_rdata, 32'h8000_0104);
        tick();
        check("csr_mtvec_o_after_write", csr_mtvec, 32'h8000_0104);

        // same-address collision: clint wins
        set_wr(1'b1, 32'h341, 32'h100, 1'b1, 32'h341, 32'h200);
        set_rd(32'h341, 32'h341);
        check("bypass_mepc_clint_wins", ex_rdata, 32'h200);
        tick();
        check("csr_mepc_o_collision", csr_mepc, 32'h200);

        // different addresses: both commit
        set_wr(1'b1, 32'h340, 32'h5A5A_5A5A, 1'b1, 32'h342, 32'h8000_0007);
        tick();
        set_rd(32'h340, 32'h342);
        check("mscratch_dual", ex_rdata, 32'h5A5A_5A5A);
        check("mcause_dual", clint_rdata, 32'h8000_0007);

        // mstatus masking from clint
        set_wr(1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 32'hFFFF_FFFF);
        tick();
        check("mstatus_all_ones", csr_mstatus, 32'h0000_1888);
        set_wr(1'b1, 32'h300, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check("mstatus_zero", csr_mstatus, 32'h0000_1800);

        inst_retire = 1'b1;
        set_wr(1'b1, 32'h304, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
        tick();
        set_rd(32'h304, 32'hB02);
        check("mie_mask", ex_rdata, 32'h0000_0888);

        // read-only and unmapped writes are dropped
        set_wr(1'b1, 32'h301, 32'h0, 1'b1, 32'hF14, 32'hFFFF_FFFF);
        tick();
        set_rd(32'h301, 32'hF14);
        check("misa_read_only", ex_rdata, MISA);
        check("mhartid_read_only", clint_rdata, HART);
        set_wr(1'b1, 32'h0000_1305, 32'hFFFF_FFFF, 1'b1, 32'h0001_0341, 32'hFFFF_FFFF);
        set_rd(32'h0000_1305, 32'h0001_0341);
        check("unmapped_ex_read", ex_rdata, 32'h0);
        tick();
        check("mtvec_alias_ignored", csr_mtvec, 32'h8000_0104);
        check("mepc_alias_ignored", csr_mepc, 32'h200);
        inst_retire = 1'b0;

        // mcycle carry into mcycleh
        set_wr(1'b1, 32'hB00, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0);
        set_rd(32'hB00, 32'hB80);
        check("bypass_mcycle", ex_rdata, 32'hFFFF_FFFE);
        check("mcycleh_before", clint_rdata, 32'h0);
        tick();
        check("mcycle_written", ex_rdata, 32'hFFFF_FFFE);
        tick();
        tick();
        check("mcycle_carry_lo", ex_rdata, 32'h0);
        check("mcycle_carry_hi", clint_rdata, 32'h1);

        // full 64-bit wrap, halves written by different ports
        set_wr(1'b1, 32'hB00, 32'hFFFF_FFFF, 1'b1, 32'hB80, 32'hFFFF_FFFF);
        #1;
        check("bypass_mcycleh", clint_rdata, 32'hFFFF_FFFF);
        tick();
        check("mcycle_max_lo", ex_rdata, 32'hFFFF_FFFF);
        check("mcycle_max_hi", clint_rdata, 32'hFFFF_FFFF);
        tick();
        check("mcycle_wrap_lo", ex_rdata, 32'h0);
        check("mcycle_wrap_hi", clint_rdata, 32'h0);

        // asynchronous reset between clock edges
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mcycle", ex_rdata, 32'h0);
        check("async_rst_mtvec", csr_mtvec, 32'h0);
        check("async_rst_mepc", csr_mepc, 32'h0);
        check("async_rst_mstatus", csr_mstatus, 32'h0000_1800);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        check("mcycle_after_release", ex_rdata, 32'h5);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
